aes_round_iter: RTL and testbench

Iterative AES encryption engine that runs a complete NR-round cipher on one 128-bit block using a single shared round datapath, one round per clock. The datapath is byte_sub, then shift_rows, then mix_columns, then round_key. It generalises the single combinational round to a sequenced multi-round core for AES-128, AES-192 and AES-256. Round keys come from an external key store indexed by the engine. The engine sits between the block-input buffer and the ciphertext output stage.

---
 rtl/aes_round_iter.sv | 182 ++++++++++++++++++
 tb/tb_aes_round_iter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_iter.sv
// Iterative AES encryption core: one shared round datapath reused for NR rounds (AES-128/192/256).
// Optional macro AES_SPLIT_ROUND_EN splits every round over two cycles through a mid register.
module aes_round_iter #(
  parameter int NR = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         busy_o
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_check
    $error("aes_round_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] r;
    t = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] blk);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(blk[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] blk);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = blk[127-32*c -: 8];
      a1 = blk[119-32*c -: 8];
      a2 = blk[111-32*c -: 8];
      a3 = blk[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

`ifdef AES_SPLIT_ROUND_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_PHASE2 = 2'd2, S_DONE = 2'd3} fsm_e;
  logic [127:0] mid_q;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd3} fsm_e;
`endif

  fsm_e         fsm_q;
  logic [127:0] state_q, out_data_q, round_d, sbsr_s, fin_s;
  logic [3:0]   rcnt_q, rk_idx_q;
  logic         in_ready_q, out_valid_q, busy_q;

  // Round datapath; the final round bypasses mix_columns.
  always_comb begin
    sbsr_s = sub_shift(state_q);
`ifdef AES_SPLIT_ROUND_EN
    fin_s = mid_q;
`else
    fin_s = sbsr_s;
`endif
    if (rcnt_q == NR_L) begin
      round_d = fin_s ^ rk_i;
    end else begin
      round_d = mix_columns(fin_s) ^ rk_i;
    end
  end

  // Control FSM with registered handshake, key index and ciphertext outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q       <= S_IDLE;
      state_q     <= 128'h0;
      out_data_q  <= 128'h0;
      rcnt_q      <= 4'd0;
      rk_idx_q    <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AES_SPLIT_ROUND_EN
      mid_q       <= 128'h0;
`endif
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (in_valid_i) begin
            state_q    <= in_data_i ^ rk_i;
            rcnt_q     <= 4'd1;
            rk_idx_q   <= 4'd1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            fsm_q      <= S_ROUND;
          end
        end
        S_ROUND: begin
`ifdef AES_SPLIT_ROUND_EN
          mid_q <= sbsr_s;
          fsm_q <= S_PHASE2;
        end
        S_PHASE2: begin
`endif
          state_q <= round_d;
          if (rcnt_q == NR_L) begin
            out_data_q  <= round_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            rk_idx_q    <= 4'd0;
            fsm_q       <= S_DONE;
          end else begin
            rcnt_q   <= rcnt_q + 4'd1;
            rk_idx_q <= rcnt_q + 4'd1;
            fsm_q    <= S_ROUND;
          end
        end
        S_DONE: begin
          // in_ready only rises after the handshake edge: no same-cycle turnaround.
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            rcnt_q      <= 4'd0;
            fsm_q       <= S_IDLE;
          end
        end
        default: begin
          fsm_q       <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          rk_idx_q    <= 4'd0;
          rcnt_q      <= 4'd0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign rk_idx_o    = rk_idx_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_aes_round_iter.sv
// Bench for aes_round_iter: three engines (NR=10/12/14) fed by bench-expanded key stores,
// checked every cycle against a byte-level AES model plus FIPS-197 literal vectors.
module tb_aes_round_iter;

`ifdef AES_SPLIT_ROUND_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  localparam logic [255:0] KEY_APPB = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_APPB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_APPB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_C1   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C2   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY_C3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C2    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_C3    = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [2:0]          in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0][127:0]   in_data, rk, out_data;
  logic [2:0][3:0]     rk_idx;
  logic [127:0]        keys [3][15];
  logic [255:0]        cur_key [3];
  logic [7:0]          sbox_t [256];
  int                  n_checks = 0;
  int                  n_fail = 0;
  int                  mst [3];
  int                  mk [3];
  logic [127:0]        mct [3];
  logic [127:0]        mout [3];

  initial forever #5 clk = ~clk;

  aes_round_iter #(.NR(10)) u_dut10 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_data_i(in_data[0]), .rk_idx_o(rk_idx[0]), .rk_i(rk[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .out_data_o(out_data[0]), .busy_o(busy[0]));
  aes_round_iter #(.NR(12)) u_dut12 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_data_i(in_data[1]), .rk_idx_o(rk_idx[1]), .rk_i(rk[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .out_data_o(out_data[1]), .busy_o(busy[1]));
  aes_round_iter #(.NR(14)) u_dut14 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .in_data_i(in_data[2]), .rk_idx_o(rk_idx[2]), .rk_i(rk[2]), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .out_data_o(out_data[2]), .busy_o(busy[2]));

  // Combinational key stores.
  assign rk[0] = keys[0][rk_idx[0]];
  assign rk[1] = keys[1][rk_idx[1]];
  assign rk[2] = keys[2][rk_idx[2]];

  function automatic int nr_of(input int n);
    return 10 + 2 * n;
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] rkey(input logic [255:0] key, input int nr, input int idx);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = mul2(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [255:0] key, input int nr, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    blk = pt ^ rkey(key, nr, 0);
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[blk[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          if (rnd < nr)
            s[4*c+row] = mul2(t[4*c+row]) ^ mul2(t[4*c+(row+1)%4]) ^ t[4*c+(row+1)%4]
                         ^ t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4];
          else
            s[4*c+row] = t[4*c+row];
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
      blk = blk ^ rkey(key, nr, rnd);
    end
    return blk;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_key(input int n, input logic [255:0] key);
    for (int i = 0; i < 15; i++) keys[n][i] = (i <= nr_of(n)) ? rkey(key, nr_of(n), i) : 128'h0;
    cur_key[n] = key;
  endtask

  task automatic present(input int n, input logic [127:0] pt);
    @(negedge clk);
    chk($sformatf("present in_ready[%0d]", n), 128'(in_ready[n]), 128'd1);
    chk($sformatf("idle rk_idx[%0d]", n), 128'(rk_idx[n]), 128'd0);
    in_valid[n] = 1'b1;
    in_data[n]  = pt;
    @(negedge clk);
    in_valid[n] = 1'b0;
    in_data[n]  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic finish(input int n, input logic [127:0] exp, input string tag);
    int len;
    len = nr_of(n) * STEP;
    for (int j = 0; j < len; j++) begin
      chk({tag, " rk_idx"}, 128'(rk_idx[n]), 128'(j / STEP + 1));
      chk({tag, " early out_valid"}, 128'(out_valid[n]), 128'd0);
      @(negedge clk);
      in_data[n] = {$urandom, $urandom, $urandom, $urandom};
    end
    chk({tag, " latency out_valid"}, 128'(out_valid[n]), 128'd1);
    chk({tag, " busy at done"}, 128'(busy[n]), 128'd0);
    chk({tag, " ciphertext"}, out_data[n], exp);
  endtask

  task automatic handshake(input int n);
    out_ready[n] = 1'b1;
    @(negedge clk);
    out_ready[n] = 1'b0;
    chk($sformatf("handshake in_ready[%0d]", n), 128'(in_ready[n]), 128'd1);
    chk($sformatf("handshake out_valid[%0d]", n), 128'(out_valid[n]), 128'd0);
  endtask

  // Reference model: idle / running for NR*STEP edges / holding a result until out_ready.
  initial begin : model
    for (int n = 0; n < 3; n++) begin
      mst[n] = 0; mk[n] = 0; mct[n] = 128'h0; mout[n] = 128'h0;
    end
    forever begin
      @(posedge clk);
      for (int n = 0; n < 3; n++) begin
        if (rst) begin
          mst[n] = 0; mout[n] = 128'h0;
        end else if (mst[n] == 0) begin
          if (in_valid[n]) begin
            mct[n] = encrypt(cur_key[n], nr_of(n), in_data[n]);
            mk[n] = 0; mst[n] = 1;
          end
        end else if (mst[n] == 1) begin
          mk[n]++;
          if (mk[n] == nr_of(n) * STEP) begin
            mout[n] = mct[n]; mst[n] = 2;
          end
        end else if (out_ready[n]) begin
          mst[n] = 0;
        end
      end
    end
  end

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        chk($sformatf("model in_ready[%0d]", n), 128'(in_ready[n]), 128'(mst[n] == 0));
        chk($sformatf("model busy[%0d]", n), 128'(busy[n]), 128'(mst[n] == 1));
        chk($sformatf("model out_valid[%0d]", n), 128'(out_valid[n]), 128'(mst[n] == 2));
        chk($sformatf("model out_data[%0d]", n), out_data[n], mout[n]);
        if (mst[n] != 2)
          chk($sformatf("model rk_idx[%0d]", n), 128'(rk_idx[n]), 128'(mst[n] == 1 ? mk[n] / STEP + 1 : 0));
      end
    end
  end

  initial begin : main
    logic [7:0] p, q;
    in_valid = 3'b000; out_ready = 3'b000; in_data = '0;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;

    chk("pin sbox[00]", 128'(sbox_t[8'h00]), 128'h63);
    chk("pin sbox[53]", 128'(sbox_t[8'h53]), 128'hed);
    chk("pin appB rk10", rkey(KEY_APPB, 10, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("pin model appB", encrypt(KEY_APPB, 10, PT_APPB), CT_APPB);
    chk("pin model C1", encrypt(KEY_C1, 10, PT_C), CT_C1);
    chk("pin model C2", encrypt(KEY_C2, 12, PT_C), CT_C2);
    chk("pin model C3", encrypt(KEY_C3, 14, PT_C), CT_C3);

    load_key(0, KEY_APPB);
    load_key(1, KEY_C2);
    load_key(2, KEY_C3);

    repeat (3) @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      chk("reset in_ready", 128'(in_ready[n]), 128'd1);
      chk("reset out_valid", 128'(out_valid[n]), 128'd0);
      chk("reset busy", 128'(busy[n]), 128'd0);
      chk("reset out_data", out_data[n], 128'h0);
      chk("reset rk_idx", 128'(rk_idx[n]), 128'd0);
    end
    rst = 1'b0;

    present(0, PT_APPB);
    finish(0, CT_APPB, "appB");

    // Back-pressure with a competing block on the input that must be ignored.
    in_valid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data[0] = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp out_valid", 128'(out_valid[0]), 128'd1);
      chk("bp out_data", out_data[0], CT_APPB);
      chk("bp in_ready", 128'(in_ready[0]), 128'd0);
    end
    load_key(0, KEY_C1);
    in_data[0]   = PT_C;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("bp release in_ready", 128'(in_ready[0]), 128'd1);
    chk("bp release out_valid", 128'(out_valid[0]), 128'd0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
    finish(0, CT_C1, "C1 after bp");
    handshake(0);

    // Reset during round 5.
    present(0, PT_C);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", 128'(out_valid[0]), 128'd0);
    chk("midrst busy", 128'(busy[0]), 128'd0);
    chk("midrst in_ready", 128'(in_ready[0]), 128'd1);
    chk("midrst out_data", out_data[0], 128'h0);
    rst = 1'b0;
    present(0, PT_C);
    finish(0, CT_C1, "C1 after reset");
    handshake(0);

    present(1, PT_C);
    finish(1, CT_C2, "C2");
    handshake(1);

    present(2, PT_C);
    finish(2, CT_C3, "C3");
    handshake(2);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
